key_bar_sequencer: RTL and testbench

//  Sequential controller for the 15-key white-bar keyboard display (H_5 at top .. L_5 at bottom).

---
 rtl/key_bar_sequencer_pkg.sv | 25 ++
 rtl/key_band_counter.sv | 62 ++++++
 rtl/key_bar_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_key_bar_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_bar_sequencer_pkg.sv
// Shared constants, owner/FSM types and the demo-code decoder for the key-bar sequencer.
package key_bar_pkg;

   localparam int         NUM_KEYS  = 15;
   localparam logic [3:0] BAND_NONE = 4'd15;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LIVE = 2'd1,
      OWN_DEMO = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIVE = 2'd1,
      HOLD = 2'd2,
      DEMO = 2'd3
   } fsm_t;

   // Code 15 is a rest and lights nothing.
   function automatic logic [NUM_KEYS-1:0] code2mask(input logic [3:0] code);
      return (code < BAND_NONE) ? (NUM_KEYS'(1) << code) : '0;
   endfunction

endpackage

// File: rtl/key_band_counter.sv
// Line-driven row/band counter for the key bars; band 15 means below the keyboard.
module key_band_counter
   import key_bar_pkg::*;
#(
   parameter int BAND_H = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       frame_start_i,
   input  logic       line_start_i,
   output logic [3:0] band_o,
   output logic [3:0] band_next_o,
   output logic       edge_o
);

   localparam int               ROW_W    = (BAND_H > 1) ? $clog2(BAND_H) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BAND_H - 1);

   logic [ROW_W-1:0] row_q, row_d;
   logic [3:0]       band_q, band_d;
   logic             edge_q, edge_d;

   always_comb begin
      row_d  = row_q;
      band_d = band_q;
      edge_d = edge_q;
      if (frame_start_i) begin
         row_d  = '0;
         band_d = 4'd0;
         edge_d = 1'b0;
      end else if (line_start_i) begin
         edge_d = 1'b0;
         if (band_q != BAND_NONE) begin
            if (row_q == ROW_LAST) begin
               // First line of the next band doubles as the boundary line.
               row_d  = '0;
               band_d = band_q + 4'd1;
               edge_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_q  <= '0;
         band_q <= BAND_NONE;
         edge_q <= 1'b0;
      end else begin
         row_q  <= row_d;
         band_q <= band_d;
         edge_q <= edge_d;
      end
   end

   assign band_o      = band_q;
   assign band_next_o = band_d;
   assign edge_o      = edge_q;

endmodule

// File: rtl/key_bar_sequencer.sv
// Key-bar display sequencer: band counter, live/demo arbiter and frame-latched highlight set.
// Define KEY_DECAY_EN to keep released keys lit for DECAY_FRAMES frames.
module key_bar_sequencer
   import key_bar_pkg::*;
#(
   parameter int BAND_H       = 32,
   parameter int IDLE_FRAMES  = 60,
   parameter int DECAY_FRAMES = 8
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iFRAME_START,
   input  logic                iLINE_START,
   input  logic [NUM_KEYS-1:0] iLIVE_KEYS,
   input  logic [3:0]          iDEMO_CODE,
   input  logic                iDEMO_VALID,
   output logic [3:0]          oBAND,
   output logic                oEDGE,
   output logic                oKEY_HIT,
   output logic [NUM_KEYS-1:0] oACTIVE_KEYS,
   output logic [1:0]          oSRC
);

   localparam int                IDLE_W   = $clog2(IDLE_FRAMES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_FRAMES);

   fsm_t                state_q, state_d;
   owner_t              src_q;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [NUM_KEYS-1:0] raw_d;
   logic [NUM_KEYS-1:0] active_q, active_d;
   logic                hit_d, hit_q;
   logic [3:0]          band_next;
   logic                live_any;

   function automatic owner_t src_of(input fsm_t s);
      case (s)
         LIVE:    return OWN_LIVE;
         DEMO:    return OWN_DEMO;
         default: return OWN_NONE;
      endcase
   endfunction

   key_band_counter #(
      .BAND_H(BAND_H)
   ) u_band (
      .clk_i        (iCLK),
      .rst_i        (iRST),
      .frame_start_i(iFRAME_START),
      .line_start_i (iLINE_START),
      .band_o       (oBAND),
      .band_next_o  (band_next),
      .edge_o       (oEDGE)
   );

   assign live_any = |iLIVE_KEYS;

   // Arbitration only moves on a frame pulse so the set never changes mid-scan.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      if (iFRAME_START) begin
         if (live_any)
            idle_cnt_d = '0;
         else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (live_any)
                  state_d = LIVE;
               else if (iDEMO_VALID && (idle_cnt_q >= IDLE_MAX))
                  state_d = DEMO;
            end
            LIVE: begin
               if (!live_any) begin
                  state_d    = HOLD;
                  idle_cnt_d = '0;
               end
            end
            HOLD: begin
               if (live_any)
                  state_d = LIVE;
               else if (idle_cnt_d == IDLE_MAX)
                  state_d = IDLE;
            end
            default: begin
               if (live_any)
                  state_d = LIVE;
               else if (!iDEMO_VALID)
                  state_d = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      case (state_d)
         LIVE:    raw_d = iLIVE_KEYS;
         DEMO:    raw_d = code2mask(iDEMO_CODE);
         default: raw_d = '0;
      endcase
   end

`ifdef KEY_DECAY_EN
   localparam int DEC_W = $clog2(DECAY_FRAMES + 1);

   logic [NUM_KEYS-1:0] raw_q;
   logic                owner_change;

   // HOLD still belongs to the live player, so its decaying keys survive LIVE->HOLD.
   function automatic owner_t family_of(input fsm_t s);
      case (s)
         LIVE, HOLD: return OWN_LIVE;
         DEMO:       return OWN_DEMO;
         default:    return OWN_NONE;
      endcase
   endfunction

   assign owner_change = (family_of(state_d) != family_of(state_q));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_decay
         logic [DEC_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (iFRAME_START) begin
               if (owner_change || raw_d[gi])
                  cnt_d = '0;
               else if (raw_q[gi])
                  cnt_d = DEC_W'(DECAY_FRAMES);
               else if (cnt_q != '0)
                  cnt_d = cnt_q - 1'b1;
            end
         end

         always_ff @(posedge iCLK) begin
            if (iRST)
               cnt_q <= '0;
            else
               cnt_q <= cnt_d;
         end

         assign active_d[gi] = iFRAME_START ? (raw_d[gi] | (cnt_d != '0)) : active_q[gi];
      end
   endgenerate

   always_ff @(posedge iCLK) begin
      if (iRST)
         raw_q <= '0;
      else if (iFRAME_START)
         raw_q <= raw_d;
   end
`else
   assign active_d = iFRAME_START ? raw_d : active_q;
`endif

   assign hit_d = (band_next != BAND_NONE) ? active_d[band_next] : 1'b0;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q    <= IDLE;
         src_q      <= OWN_NONE;
         idle_cnt_q <= '0;
         active_q   <= '0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_of(state_d);
         idle_cnt_q <= idle_cnt_d;
         active_q   <= active_d;
         hit_q      <= hit_d;
      end
   end

   assign oKEY_HIT     = hit_q;
   assign oACTIVE_KEYS = active_q;
   assign oSRC         = src_q;

endmodule

// File: tb/tb_key_bar_sequencer.sv
// Randomized bench for key_bar_sequencer against a frame/line-level reference model.
module tb_key_bar_sequencer;

   localparam int NK     = 15;
   localparam int BH     = 32;
   localparam int LAST   = BH * NK;   // line 480: first line below the keyboard
   localparam int IDLE_N = 60;
   localparam int DECAY  = 8;

   localparam int S_IDLE = 0;
   localparam int S_LIVE = 1;
   localparam int S_HOLD = 2;
   localparam int S_DEMO = 3;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b1;
   logic          iFRAME_START = 1'b0;
   logic          iLINE_START = 1'b0;
   logic [NK-1:0] iLIVE_KEYS = '0;
   logic [3:0]    iDEMO_CODE = 4'd15;
   logic          iDEMO_VALID = 1'b0;
   logic [3:0]    oBAND;
   logic          oEDGE;
   logic          oKEY_HIT;
   logic [NK-1:0] oACTIVE_KEYS;
   logic [1:0]    oSRC;

   int checks = 0;
   int errors = 0;
   int frame_no = 0;

   // Reference model state
   bit            m_valid;
   int            m_line;
   int            m_state;
   int            m_idle;
   logic [NK-1:0] m_active;
   logic [NK-1:0] m_last_raw;
   int            m_timer [NK];

   key_bar_sequencer dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iFRAME_START(iFRAME_START),
      .iLINE_START (iLINE_START),
      .iLIVE_KEYS  (iLIVE_KEYS),
      .iDEMO_CODE  (iDEMO_CODE),
      .iDEMO_VALID (iDEMO_VALID),
      .oBAND       (oBAND),
      .oEDGE       (oEDGE),
      .oKEY_HIT    (oKEY_HIT),
      .oACTIVE_KEYS(oACTIVE_KEYS),
      .oSRC        (oSRC)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int owner_of(input int s);
      return (s == S_LIVE) ? 1 : (s == S_DEMO) ? 2 : 0;
   endfunction

   function automatic int family_of(input int s);
      return (s == S_LIVE || s == S_HOLD) ? 1 : (s == S_DEMO) ? 2 : 0;
   endfunction

   function automatic int exp_band();
      if (!m_valid || m_line >= LAST) return 15;
      return m_line / BH;
   endfunction

   function automatic bit exp_edge();
      return m_valid && (m_line % BH == 0) && (m_line >= BH) && (m_line <= LAST);
   endfunction

   task automatic model_reset();
      m_valid    = 1'b0;
      m_line     = 0;
      m_state    = S_IDLE;
      m_idle     = 0;
      m_active   = '0;
      m_last_raw = '0;
      for (int k = 0; k < NK; k++) m_timer[k] = 0;
   endtask

   task automatic model_frame(input logic [NK-1:0] live, input logic [3:0] code, input bit dv);
      int            old_state = m_state;
      int            idle_before = m_idle;
      bit            any = (live != 0);
      logic [NK-1:0] raw = '0;
      logic [NK-1:0] one = 1;
      m_idle = any ? 0 : ((m_idle < IDLE_N) ? m_idle + 1 : IDLE_N);
      if (old_state == S_IDLE) begin
         if (any) m_state = S_LIVE;
         else if (dv && idle_before >= IDLE_N) m_state = S_DEMO;
      end else if (old_state == S_LIVE) begin
         if (!any) begin m_state = S_HOLD; m_idle = 0; end
      end else if (old_state == S_HOLD) begin
         if (any) m_state = S_LIVE;
         else if (m_idle == IDLE_N) m_state = S_IDLE;
      end else begin
         if (any) m_state = S_LIVE;
         else if (!dv) m_state = S_IDLE;
      end
      if (m_state == S_LIVE) raw = live;
      else if (m_state == S_DEMO && code < 15) raw = one << code;
`ifdef KEY_DECAY_EN
      m_active = raw;
      for (int k = 0; k < NK; k++) begin
         if (family_of(m_state) != family_of(old_state) || raw[k]) m_timer[k] = 0;
         else if (m_last_raw[k]) m_timer[k] = DECAY;
         else if (m_timer[k] > 0) m_timer[k]--;
         if (m_timer[k] > 0) m_active[k] = 1'b1;
      end
`else
      m_active = raw;
`endif
      m_last_raw = raw;
   endtask

   task automatic compare_all();
      int b = exp_band();
      chk("band", 32'(oBAND), 32'(b));
      chk("edge", 32'(oEDGE), 32'(exp_edge()));
      chk("hit", 32'(oKEY_HIT), (b < 15) ? 32'(m_active[b]) : 32'd0);
      chk("active", 32'(oACTIVE_KEYS), 32'(m_active));
      chk("src", 32'(oSRC), 32'(owner_of(m_state)));
   endtask

   // One clock: drive pulses, advance model at the edge, compare just after it.
   task automatic step(input bit fs, input bit ls, input bit rst);
      iFRAME_START = fs;
      iLINE_START  = ls;
      iRST         = rst;
      @(posedge iCLK);
      if (rst) model_reset();
      else if (fs) begin
         m_valid = 1'b1;
         m_line  = 0;
         model_frame(iLIVE_KEYS, iDEMO_CODE, iDEMO_VALID);
      end else if (ls && m_valid && m_line <= LAST) m_line++;
      #1;
      compare_all();
      iFRAME_START = 1'b0;
      iLINE_START  = 1'b0;
      iRST         = 1'b0;
   endtask

   task automatic run_frame(input int nlines, input logic [NK-1:0] live, input logic [3:0] code,
                            input bit dv, input bit churn);
      iLIVE_KEYS  = live;
      iDEMO_CODE  = code;
      iDEMO_VALID = dv;
      step(1'b1, churn && ($urandom_range(0, 5) == 0), 1'b0);
      $display("frame %0d: live=%h code=%0d valid=%0b -> src=%0d active=%h",
               frame_no, live, code, dv, oSRC, oACTIVE_KEYS);
      frame_no++;
      for (int i = 0; i < nlines; i++) begin
         if (churn && $urandom_range(0, 7) == 0) iLIVE_KEYS = NK'($urandom);
         if (churn && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
         if (churn && $urandom_range(0, 400) == 0) step(1'b0, 1'b0, 1'b1);
         else step(1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      int            edges;
      int            bad_hits;
      logic [NK-1:0] live;

      // Reset state
      model_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("reset_band", 32'(oBAND), 32'd15);
      chk("reset_active", 32'(oACTIVE_KEYS), 32'd0);
      step(1'b0, 1'b1, 1'b0);

      // Full frame scan: 15 boundary lines, then band holds at 15
      step(1'b1, 1'b0, 1'b0);
      edges = 0;
      for (int i = 0; i < LAST + 5; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (oEDGE) edges++;
      end
      chk("scan_edges", 32'(edges), 32'd15);
      chk("scan_hold15", 32'(oBAND), 32'd15);

      // Single live key lights only band 0
      run_frame(0, 15'h0001, 4'd15, 1'b0, 1'b0);
      chk("live_src", 32'(oSRC), 32'd1);
      chk("live_active", 32'(oACTIVE_KEYS), 32'h0001);
      bad_hits = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (oKEY_HIT && oBAND != 4'd0) bad_hits++;
      end
      chk("live_hit_band0_only", 32'(bad_hits), 32'd0);

      // Live goes idle; demo takes over after the idle window
      for (int f = 0; f < IDLE_N + 5; f++) run_frame(2, '0, 4'd7, 1'b1, 1'b0);
      chk("demo_src", 32'(oSRC), 32'd2);
      chk("demo_active", 32'(oACTIVE_KEYS), 32'h0080);
      run_frame(3, '0, 4'd15, 1'b1, 1'b0);
      run_frame(3, '0, 4'd15, 1'b1, 1'b0);

      // Live preempts demo in the same frame
      run_frame(0, 15'h4000, 4'd7, 1'b1, 1'b0);
      chk("preempt_src", 32'(oSRC), 32'd1);
      chk("preempt_active", 32'(oACTIVE_KEYS), 32'h4000);

      // Mid-frame key change does not disturb the latched set
      iLIVE_KEYS = 15'h0003;
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
      chk("midframe_latched", 32'(oACTIVE_KEYS), 32'h4000);

      // Reset mid-frame, then coincident frame+line pulse
      run_frame(100, 15'h0010, 4'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("midreset_band", 32'(oBAND), 32'd15);
      chk("midreset_src", 32'(oSRC), 32'd0);
      chk("midreset_active", 32'(oACTIVE_KEYS), 32'd0);
      iLIVE_KEYS = 15'h0001;
      step(1'b1, 1'b1, 1'b0);
      chk("coincident_band", 32'(oBAND), 32'd0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);

      // Long idle stretch with random demo notes
      for (int f = 0; f < IDLE_N + 12; f++)
         run_frame($urandom_range(0, 4), '0, 4'($urandom_range(0, 15)), 1'b1, 1'b1);

      // Random mix
      for (int f = 0; f < 150; f++) begin
         live = ($urandom_range(0, 2) == 0) ? NK'($urandom) : '0;
         if ($urandom_range(0, 3) == 0) live = NK'(1) << $urandom_range(0, NK - 1);
         run_frame($urandom_range(0, 40), live, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
